// File: rtl/l2_cache_control.sv
// l2_cache_control: L2 sequencing FSM (compare, writeback, fill) with per-set tree PLRU victim choice
module l2_cache_control #(
    parameter int SETS  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [IDX_W-1:0] set_index,
    input  logic [3:0]       way_hit,
    input  logic [3:0]       way_valid,
    input  logic [3:0]       way_dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic [1:0]       way_sel,
    output logic             way_write_en,
    output logic             data_src_sel,
    output logic             set_dirty,
    output logic             load_tag,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel
);
    typedef enum logic [1:0] {IDLE, CMP, WB, FILL} state_t;

    state_t     state, state_next;
    logic [2:0] plru [SETS];
    logic [2:0] plru_cur, plru_upd;
    logic [1:0] victim, hit_way, inv_way, lru_way, miss_way;
    logic       req, hit;

    assign req      = mem_read | mem_write;
    assign hit      = |way_hit;
    assign plru_cur = plru[set_index];

    // PLRU bits are stored as {b0, b1, b2}; pick hit/victim ways and the post-hit PLRU value
    always_comb begin
        hit_way  = way_hit[0] ? 2'd0 : way_hit[1] ? 2'd1 : way_hit[2] ? 2'd2 : 2'd3;
        inv_way  = !way_valid[0] ? 2'd0 : !way_valid[1] ? 2'd1 : !way_valid[2] ? 2'd2 : 2'd3;
        lru_way  = plru_cur[2] ? (plru_cur[0] ? 2'd3 : 2'd2) : (plru_cur[1] ? 2'd1 : 2'd0);
        miss_way = (&way_valid) ? lru_way : inv_way;
        plru_upd = hit_way[1] ? {1'b0, plru_cur[1], ~hit_way[0]} : {1'b1, ~hit_way[0], plru_cur[0]};
    end

    // next-state and output decode; IDLE leaves every output low
    always_comb begin
        state_next    = state;
        mem_resp      = 1'b0;
        way_sel       = 2'd0;
        way_write_en  = 1'b0;
        data_src_sel  = 1'b0;
        set_dirty     = 1'b0;
        load_tag      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state)
            IDLE: state_next = req ? CMP : IDLE;
            CMP: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (hit) begin
                    way_sel      = hit_way;
                    mem_resp     = 1'b1;
                    way_write_en = mem_write;
                    set_dirty    = mem_write;
                    state_next   = IDLE;
                end else begin
                    way_sel    = miss_way;
                    state_next = (way_valid[miss_way] && way_dirty[miss_way]) ? WB : FILL;
                end
            end
            WB: begin
                way_sel       = victim;
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                state_next    = pmem_resp ? FILL : WB;
            end
            FILL: begin
                way_sel      = victim;
                pmem_read    = 1'b1;
                way_write_en = pmem_resp;
                data_src_sel = pmem_resp;
                load_tag     = pmem_resp;
                state_next   = pmem_resp ? CMP : FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    // state, victim capture on a miss, PLRU update on a hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            victim <= 2'd0;
            for (int i = 0; i < SETS; i++) plru[i] <= 3'b000;
        end else begin
            state <= state_next;
            if (state == CMP && req && !hit) victim <= miss_way;
            if (state == CMP && req && hit) plru[set_index] <= plru_upd;
        end
    end
endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Sequencing controller for the 4-way L2 cache datapath. It turns L1-side requests into tag-compare, writeback and fill sequences on the physical-memory port. It keeps a 3-bit tree pseudo-LRU per set and chooses victims. It drives the way-select/write-enable pair consumed by the L2 way-write decoder, plus the data, tag and address steering controls for the L2 datapath.

## Interface
Parameters:
- SETS, 8, number of sets; one PLRU entry per set
- IDX_W, 3, width of set_index (log2 SETS)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_read  in  1  L1 read request; held until mem_resp
- mem_write  in  1  L1 write request; held until mem_resp; never asserted together with mem_read
- set_index  in  IDX_W  set of current request; stable while request held
- way_hit  in  4  tag-match vector, bit0=A .. bit3=D; valid in CMP
- way_valid  in  4  valid bits of indexed set
- way_dirty  in  4  dirty bits of indexed set
- pmem_resp  in  1  physical memory completion pulse
- mem_resp  out  1  one-cycle completion pulse to L1
- way_sel  out  2  way index to write decoder: 0=A, 1=B, 2=C, 3=D
- way_write_en  out  1  write strobe to write decoder
- data_src_sel  out  1  0=L1 write data, 1=pmem fill data
- set_dirty  out  1  set dirty bit of way_sel (write hit)
- load_tag  out  1  load tag, set valid, clear dirty of way_sel (fill)
- pmem_read  out  1  fill request, held until pmem_resp
- pmem_write  out  1  writeback request, held until pmem_resp
- pmem_addr_sel  out  1  0=request address, 1=victim tag/set address

## Operation
- States: IDLE, CMP, WB, FILL.
- IDLE: all outputs 0. If mem_read or mem_write is high, go to CMP. IDLE gives the arrays one read cycle.
- CMP with no request: return to IDLE with no side effects.
- CMP hit (way_hit != 0):
  - way_sel = encoded hit way, combinational. If more than one bit is set, the lowest index wins.
  - mem_resp = 1.
  - Write: way_write_en = 1, set_dirty = 1, data_src_sel = 0.
  - PLRU[set_index] updated; go to IDLE.
- CMP miss:
  - Victim = lowest-index way with way_valid = 0. If all ways are valid, victim = PLRU choice.
  - Victim is registered, and way_sel drives it until the fill completes.
  - If the victim is valid and dirty, go to WB; otherwise go to FILL.
  - No mem_resp and no PLRU update on a miss.
- WB: pmem_write = 1, pmem_addr_sel = 1. On pmem_resp, go to FILL.
- FILL: pmem_read = 1, pmem_addr_sel = 0.
  - In the pmem_resp cycle: way_write_en = 1, data_src_sel = 1, load_tag = 1.
  - Then go to CMP, which now hits and responds.
- PLRU bits per set are [b0, b1, b2].
  - b0 = 0 sends the victim to A/B; b0 = 1 sends it to C/D.
  - b1 picks A(0) or B(1). b2 picks C(0) or D(1).
  - Update on a hit to A: b0 = 1, b1 = 1. B: b0 = 1, b1 = 0. C: b0 = 0, b2 = 1. D: b0 = 0, b2 = 0. Untouched bits hold.
- A request dropped during WB/FILL does not abort the sequence. The pmem transaction completes, the line is installed, and CMP then returns to IDLE without mem_resp.

## Timing
- Reset (async assert): state = IDLE, all PLRU entries = 0, registered victim = 0. All outputs are 0 immediately.
- Reset mid-WB/FILL: the outstanding pmem transaction is abandoned and pmem_read/pmem_write drop at once. Release is synchronous to the next clk edge.
- Read/write hit: request seen in IDLE at cycle 0; mem_resp and the write strobe occur in cycle 1 (CMP).
- Clean miss: 2 + fill wait cycles + 1 cycle to mem_resp. The fill write happens in the pmem_resp cycle and mem_resp follows in the next cycle.
- Dirty miss: adds the WB wait cycles before FILL. pmem_write and pmem_read are never high in the same cycle.
- L1 deasserts its request in the cycle after mem_resp. A request present in IDLE is always treated as new.
- Output decode: way_write_en, mem_resp, set_dirty, load_tag, data_src_sel and way_sel are combinational from state and inputs. The PLRU and victim registers update on the clk edge.

## Test plan
- Reset, then read to set 0 with all ways invalid → FILL of way A (way_sel = 0, load_tag = 1), then mem_resp; PLRU[0] = 3'b110 (b0 = 1, b1 = 1).
- Write hit on way C in set 2 → in cycle 1: way_sel = 2, way_write_en = 1, set_dirty = 1, data_src_sel = 0, mem_resp = 1; PLRU[2] b0 = 0, b2 = 1.
- Set 1 fully valid, PLRU = 0, way A dirty, read miss → WB (pmem_write, pmem_addr_sel = 1) until pmem_resp, then FILL into way A, then mem_resp.
- Hits on A, C, B, D in set 3 in that order, then a miss with all ways valid and clean → victim = way A (PLRU = b0 0, b1 0, b2 0).
- way_hit = 4'b1010 in CMP → way_sel = 1 (lowest index).
- reset_n asserted during FILL with pmem_read high → pmem_read = 0 and state = IDLE without waiting for a clock edge; after release, next request takes the miss path.
